// File: rtl/epd_pkg.sv
// ---------------------------------------------------------------------------
// epd_pkg
//   Shared definitions for the EPD source-driver data path.
//   - 2bpp pixel codes driven on the source bus (4 pixels per byte,
//     pixel 0 in bits [1:0]).
//   - Feeder FSM state encoding.
//   - Byte constants and a helper for the built-in checkerboard pattern
//     (only used when EPD_TEST_PATTERN_EN is defined).
// ---------------------------------------------------------------------------
package epd_pkg;

  localparam logic [1:0] PIX_NOP   = 2'b00;
  localparam logic [1:0] PIX_BLACK = 2'b01;
  localparam logic [1:0] PIX_WHITE = 2'b10;

  // A full byte of one code: all four pixels identical.
  localparam logic [7:0] BYTE_NOP   = {4{PIX_NOP}};    // 8'h00
  localparam logic [7:0] BYTE_BLACK = {4{PIX_BLACK}};  // 8'h55
  localparam logic [7:0] BYTE_WHITE = {4{PIX_WHITE}};  // 8'hAA

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    SHIFT     = 2'd2,
    LINE_END  = 2'd3
  } feeder_state_e;

  // Checkerboard: toggles every 8 lines and every 2 beats (8 pixels).
  function automatic logic [7:0] pattern_byte(input logic line_bit3,
                                              input logic beat_bit1);
    return (line_bit3 ^ beat_bit1) ? BYTE_BLACK : BYTE_WHITE;
  endfunction

endpackage

// File: rtl/epd_sync_fifo.sv
// ---------------------------------------------------------------------------
// epd_sync_fifo
//   Single-clock first-word-fall-through FIFO used as the pixel prefetch
//   buffer. rd_data shows the head entry whenever empty is low; rd_en pops.
//   full and empty are registered, so a push that frees the FIFO from empty
//   becomes visible one cycle later, and a pop from a full FIFO does not
//   make room for a push in the same cycle.
//
// Ports
//   clk_25m  in   clock
//   rst      in   synchronous active-high reset (pointers/flags only)
//   wr_data  in   DATA_W  byte to store
//   wr_en    in   write request; ignored while full
//   full     out  registered full flag
//   rd_en    in   pop request; ignored while empty
//   rd_data  out  DATA_W  head of the FIFO
//   empty    out  registered empty flag
// ---------------------------------------------------------------------------
module epd_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16   // power of 2, >= 2
) (
  input  logic              clk_25m,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty
);

  localparam int            AW         = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic              push;
  logic              pop;
  logic              full_q;
  logic              empty_q;

  assign push = wr_en && !full_q;
  assign pop  = rd_en && !empty_q;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every always_ff
  // sees the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk_25m) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      full_q  <= (count_next == FULL_COUNT);
      empty_q <= (count_next == '0);
    end
  end

  // NOTE: the storage array has no reset; the pointers and flags define which
  // entries are valid, and a resettable array would cost a flop per bit.
  always_ff @(posedge clk_25m) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/epd_source_data_feeder.sv
// ---------------------------------------------------------------------------
// epd_source_data_feeder
//   Source-driver data stage behind the EPD frame timing controller.
//   Prefetches packed 2bpp pixel bytes into a FIFO and, on each S_Data pulse,
//   shifts one line of WIDTH/4 bytes onto D (one per clk_25m, in step with
//   XCL). Counts lines, flags underruns and overlapping S_Data pulses, and
//   pulses frame_done after the last byte of line HIGH-1.
//
//   S_Data sampled at edge t -> first byte on D after edge t+1, last byte
//   after edge t+WIDTH/4, one LINE_END cycle after that.
//
// Optional feature (macro EPD_TEST_PATTERN_EN):
//   adds input pat_en; while high, SHIFT beats output a black/white
//   checkerboard instead of FIFO data and the FIFO is left untouched.
//
// Ports
//   clk_25m     in   sole clock (same clock as XCL)
//   rst         in   synchronous active-high reset
//   S_Frame     in   frame start pulse; aborts any line in progress
//   S_Data      in   line data start pulse
//   in_data     in   8  four pixel codes, pixel 0 in [1:0]
//   in_valid    in   upstream byte valid
//   in_ready    out  FIFO can accept a byte
//   D           out  8  source-driver data bus
//   d_en        out  high while D carries line data
//   frame_done  out  1-cycle pulse after the last byte of the frame
//   underrun    out  sticky: FIFO was empty on a data beat
//   overlap     out  sticky: S_Data arrived during SHIFT
//   pat_en      in   (EPD_TEST_PATTERN_EN only) select checkerboard pattern
// ---------------------------------------------------------------------------
module epd_source_data_feeder
  import epd_pkg::*;
#(
  parameter int WIDTH      = 1200,  // pixels per line, multiple of 4
  parameter int HIGH       = 825,   // lines per frame
  parameter int FIFO_DEPTH = 16     // prefetch depth in bytes, power of 2
) (
  input  logic       clk_25m,
  input  logic       rst,
  input  logic       S_Frame,
  input  logic       S_Data,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] D,
  output logic       d_en,
  output logic       frame_done,
  output logic       underrun,
  output logic       overlap
`ifdef EPD_TEST_PATTERN_EN
 ,input  logic       pat_en
`endif
);

  localparam int BYTES_PER_LINE = WIDTH / 4;
  localparam int BEAT_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam int LINE_W = (HIGH > 1) ? $clog2(HIGH) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BYTES_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(HIGH - 1);

  feeder_state_e     state_q;
  logic [BEAT_W-1:0] beat_q;
  logic [LINE_W-1:0] line_q;
  logic [7:0]        d_q;
  logic              d_en_q;
  logic              frame_done_q;
  logic              underrun_q;
  logic              overlap_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_rd_data;
  logic              fifo_pop;
  logic              pat_beat;
  logic [7:0]        beat_byte;
  logic              beat_starved;

  epd_sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_25m (clk_25m),
    .rst     (rst),
    .wr_data (in_data),
    .wr_en   (in_valid),
    .full    (fifo_full),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  assign in_ready = !fifo_full;

`ifdef EPD_TEST_PATTERN_EN
  // Zero-extend so bit 3 / bit 1 exist even for tiny HIGH / WIDTH settings.
  logic [15:0] line_ext;
  logic [15:0] beat_ext;
  logic [7:0]  pat_byte;
  assign line_ext = 16'(line_q);
  assign beat_ext = 16'(beat_q);
  assign pat_byte = pattern_byte(line_ext[3], beat_ext[1]);
  assign pat_beat = pat_en;
`else
  assign pat_beat = 1'b0;
`endif

  // Byte for the current beat. A beat is only emitted in SHIFT when S_Frame
  // is not aborting the line, so the FIFO is never popped on an abort edge.
  always_comb begin
    beat_byte    = BYTE_NOP;
    fifo_pop     = 1'b0;
    beat_starved = 1'b0;
    if (state_q == SHIFT && !S_Frame) begin
      if (pat_beat) begin
`ifdef EPD_TEST_PATTERN_EN
        beat_byte = pat_byte;
`endif
      end else if (!fifo_empty) begin
        beat_byte = fifo_rd_data;
        fifo_pop  = 1'b1;
      end else begin
        beat_starved = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      line_q       <= '0;
      d_q          <= '0;
      d_en_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      overlap_q    <= 1'b0;
    end else begin
      d_q          <= BYTE_NOP;
      d_en_q       <= 1'b0;
      frame_done_q <= 1'b0;

      if (S_Frame) begin
        // Frame start wins over everything, including a coincident S_Data.
        state_q <= WAIT_LINE;
        line_q  <= '0;
        beat_q  <= '0;
        if (state_q != IDLE) begin
          underrun_q <= 1'b0;
          overlap_q  <= 1'b0;
        end
      end else begin
        unique case (state_q)
          IDLE: ;  // S_Data is ignored until a frame starts

          WAIT_LINE: begin
            if (S_Data) begin
              state_q <= SHIFT;
              beat_q  <= '0;
            end
          end

          SHIFT: begin
            d_q    <= beat_byte;
            d_en_q <= 1'b1;
            if (beat_starved) underrun_q <= 1'b1;
            if (S_Data)       overlap_q  <= 1'b1;
            // The beat counter advances on starved beats too, so a line
            // always lasts exactly BYTES_PER_LINE cycles.
            if (beat_q == LAST_BEAT) begin
              state_q <= LINE_END;
              beat_q  <= '0;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end

          LINE_END: begin
            if (line_q == LAST_LINE) begin
              line_q       <= '0;
              frame_done_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              line_q  <= line_q + 1'b1;
              state_q <= WAIT_LINE;
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign D          = d_q;
  assign d_en       = d_en_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign overlap    = overlap_q;

endmodule
